// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller and the accumulator datapath.
// The controller holds the master modport; the datapath (or bench) holds the slave modport.
interface multicycle_controller_if;
    logic [3:0] Op;
    logic [8:0] Func;
    logic       Zero;

    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic       PCWrite;
    logic       OldPCWrite;
    logic       MDRWrite;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ImmSrc;
    logic [2:0] ALUControl;
    logic       A3Src;
    logic [1:0] PCSrc;
    logic       ResultSrc;
    logic       illegal;
    logic [3:0] state;

    modport master (
        input  Op, Func, Zero,
        output AdrSrc, MemWrite, IRWrite, RegWrite, PCWrite, OldPCWrite, MDRWrite,
               ALUSrcA, ALUSrcB, ImmSrc, ALUControl, A3Src, PCSrc, ResultSrc,
               illegal, state
    );

    modport slave (
        output Op, Func, Zero,
        input  AdrSrc, MemWrite, IRWrite, RegWrite, PCWrite, OldPCWrite, MDRWrite,
               ALUSrcA, ALUSrcB, ImmSrc, ALUControl, A3Src, PCSrc, ResultSrc,
               illegal, state
    );
endinterface

// File: rtl/multicycle_controller.sv
// Moore FSM sequencing the 16-bit accumulator multicycle datapath
// (fetch, decode, execute, memory, writeback) with a sticky illegal-opcode flag.
module multicycle_controller (
    input  logic                          clk,
    input  logic                          reset,
    multicycle_controller_if.master       ctrl
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_LD_ADR = 4'd2,
        S_LD_MEM = 4'd3,
        S_LD_WB  = 4'd4,
        S_ST_ADR = 4'd5,
        S_ST_MEM = 4'd6,
        S_JMP    = 4'd7,
        S_BRZ    = 4'd8,
        S_C_EX   = 4'd9,
        S_C_WB   = 4'd10,
        S_I_EX   = 4'd11,
        S_I_WB   = 4'd12,
        S_ILL    = 4'd15
    } state_t;

    typedef enum logic [2:0] {
        F_MOVETO   = 3'd0,
        F_MOVEFROM = 3'd1,
        F_ADD      = 3'd2,
        F_SUB      = 3'd3,
        F_AND      = 3'd4,
        F_OR       = 3'd5,
        F_NOT      = 3'd6,
        F_NOP      = 3'd7
    } func_t;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_AND   = 3'b010;
    localparam logic [2:0] ALU_OR    = 3'b011;
    localparam logic [2:0] ALU_NOT   = 3'b100;
    localparam logic [2:0] ALU_PASSA = 3'b110;
    localparam logic [2:0] ALU_PASSB = 3'b111;

    state_t     stateReg;
    state_t     nextState;
    func_t      decodedFunc;
    func_t      funcReg;
    logic [1:0] immOpReg;
    logic       illegalReg;
    logic       unusedFuncHigh;

    // Func[8:7] only ever mean NOP, which is already implied by Func[6:0] being zero.
    assign unusedFuncHigh = ^ctrl.Func[8:7];

    // Lowest set Func bit wins; no bit in [6:0] means NOP.
    always_comb begin
        decodedFunc = F_NOP;
        if      (ctrl.Func[0]) decodedFunc = F_MOVETO;
        else if (ctrl.Func[1]) decodedFunc = F_MOVEFROM;
        else if (ctrl.Func[2]) decodedFunc = F_ADD;
        else if (ctrl.Func[3]) decodedFunc = F_SUB;
        else if (ctrl.Func[4]) decodedFunc = F_AND;
        else if (ctrl.Func[5]) decodedFunc = F_OR;
        else if (ctrl.Func[6]) decodedFunc = F_NOT;
    end

    // The instruction register only changes in FETCH, so the operation is latched
    // in DECODE and the later phases never look at Op/Func again.
    always_ff @(posedge clk) begin
        if (reset) begin
            stateReg   <= S_FETCH;
            funcReg    <= F_NOP;
            immOpReg   <= 2'b00;
            illegalReg <= 1'b0;
        end else begin
            stateReg <= nextState;
            if (stateReg == S_DECODE) begin
                funcReg  <= decodedFunc;
                immOpReg <= ctrl.Op[1:0];
            end
            if (nextState == S_ILL) begin
                illegalReg <= 1'b1;
            end
        end
    end

    always_comb begin
        nextState       = S_FETCH;
        ctrl.AdrSrc     = 1'b0;
        ctrl.MemWrite   = 1'b0;
        ctrl.IRWrite    = 1'b0;
        ctrl.RegWrite   = 1'b0;
        ctrl.PCWrite    = 1'b0;
        ctrl.OldPCWrite = 1'b0;
        ctrl.MDRWrite   = 1'b0;
        ctrl.ALUSrcA    = 2'b00;
        ctrl.ALUSrcB    = 2'b00;
        ctrl.ImmSrc     = 2'b00;
        ctrl.ALUControl = ALU_ADD;
        ctrl.A3Src      = 1'b0;
        ctrl.PCSrc      = 2'b00;
        ctrl.ResultSrc  = 1'b0;

        case (stateReg)
            S_FETCH: begin
                ctrl.IRWrite    = 1'b1;
                ctrl.OldPCWrite = 1'b1;
                ctrl.ALUSrcB    = 2'b01;
                ctrl.PCWrite    = 1'b1;
                nextState       = S_DECODE;
            end
            S_DECODE: begin
                case (ctrl.Op)
                    4'b0000: nextState = S_LD_ADR;
                    4'b0001: nextState = S_ST_ADR;
                    4'b0010: nextState = S_JMP;
                    4'b0100: nextState = S_BRZ;
                    4'b1000: nextState = (decodedFunc == F_NOP) ? S_FETCH : S_C_EX;
                    4'b1100, 4'b1101, 4'b1110, 4'b1111: nextState = S_I_EX;
                    default: nextState = S_ILL;
                endcase
            end
            S_LD_ADR, S_ST_ADR: begin
                ctrl.ALUSrcB    = 2'b10;
                ctrl.ALUControl = ALU_PASSB;
                nextState       = (stateReg == S_LD_ADR) ? S_LD_MEM : S_ST_MEM;
            end
            S_LD_MEM: begin
                ctrl.AdrSrc   = 1'b1;
                ctrl.MDRWrite = 1'b1;
                nextState     = S_LD_WB;
            end
            S_LD_WB: begin
                ctrl.RegWrite  = 1'b1;
                ctrl.ResultSrc = 1'b1;
            end
            S_ST_MEM: begin
                ctrl.AdrSrc   = 1'b1;
                ctrl.MemWrite = 1'b1;
            end
            S_JMP: begin
                ctrl.PCSrc   = 2'b01;
                ctrl.PCWrite = 1'b1;
            end
            S_BRZ: begin
                ctrl.ALUSrcA    = 2'b10;
                ctrl.ALUControl = ALU_PASSA;
                ctrl.PCSrc      = 2'b10;
                ctrl.PCWrite    = ctrl.Zero;
            end
            S_C_EX: begin
                ctrl.ALUSrcA = 2'b10;
                case (funcReg)
                    F_MOVETO:   ctrl.ALUControl = ALU_PASSA;
                    F_MOVEFROM: ctrl.ALUControl = ALU_PASSB;
                    F_ADD:      ctrl.ALUControl = ALU_ADD;
                    F_SUB:      ctrl.ALUControl = ALU_SUB;
                    F_AND:      ctrl.ALUControl = ALU_AND;
                    F_OR:       ctrl.ALUControl = ALU_OR;
                    F_NOT:      ctrl.ALUControl = ALU_NOT;
                    default:    ctrl.ALUControl = ALU_ADD;
                endcase
                nextState = S_C_WB;
            end
            S_C_WB: begin
                ctrl.RegWrite = 1'b1;
                ctrl.A3Src    = (funcReg == F_MOVETO);
            end
            S_I_EX: begin
                ctrl.ALUSrcA = 2'b10;
                ctrl.ALUSrcB = 2'b10;
                case (immOpReg)
                    2'b00: begin ctrl.ImmSrc = 2'b01; ctrl.ALUControl = ALU_ADD; end
                    2'b01: begin ctrl.ImmSrc = 2'b01; ctrl.ALUControl = ALU_SUB; end
                    2'b10: begin ctrl.ImmSrc = 2'b00; ctrl.ALUControl = ALU_AND; end
                    default: begin ctrl.ImmSrc = 2'b00; ctrl.ALUControl = ALU_OR; end
                endcase
                nextState = S_I_WB;
            end
            S_I_WB: begin
                ctrl.RegWrite = 1'b1;
            end
            S_ILL: begin
                nextState = S_ILL;
            end
            default: begin
                nextState = S_FETCH;
            end
        endcase

        // A reset edge must never commit a partial write from an abandoned instruction.
        if (reset) begin
            ctrl.MemWrite   = 1'b0;
            ctrl.IRWrite    = 1'b0;
            ctrl.RegWrite   = 1'b0;
            ctrl.PCWrite    = 1'b0;
            ctrl.OldPCWrite = 1'b0;
            ctrl.MDRWrite   = 1'b0;
        end
    end

    assign ctrl.state   = stateReg;
    assign ctrl.illegal = illegalReg;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: directed instructions push the expected
// per-cycle control vector; an independent negedge monitor pops and compares.
module tb_multicycle_controller;

    typedef struct packed {
        logic [3:0] st;
        logic       adr, mw, irw, rw, pcw, opcw, mdrw;
        logic [1:0] srca, srcb, imm;
        logic [2:0] aluc;
        logic       a3;
        logic [1:0] pcs;
        logic       res, ill;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   passes = 0;
    vec_t  expQ[$];
    string nameQ[$];

    multicycle_controller_if bus ();

    multicycle_controller dut (
        .clk   (clk),
        .reset (reset),
        .ctrl  (bus)
    );

    always #5 clk = ~clk;

    // Monitor: the controller presents a new control vector every cycle.
    always @(negedge clk) begin
        if (expQ.size() > 0) begin
            vec_t  e;
            vec_t  a;
            string n;
            e = expQ.pop_front();
            n = nameQ.pop_front();
            a = '{bus.state, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.RegWrite, bus.PCWrite,
                  bus.OldPCWrite, bus.MDRWrite, bus.ALUSrcA, bus.ALUSrcB, bus.ImmSrc,
                  bus.ALUControl, bus.A3Src, bus.PCSrc, bus.ResultSrc, bus.illegal};
            checks++;
            if (a === e) passes++;
            else $display("[TB] FAIL %s: got %h required %h (state got %0d required %0d)",
                          n, a, e, a.st, e.st);
        end
    end

    function automatic vec_t vBlank(input logic [3:0] st);
        vec_t v = '0;
        v.st = st;
        return v;
    endfunction

    function automatic vec_t vFetch(input logic inReset);
        vec_t v = vBlank(4'd0);
        v.irw  = !inReset;
        v.opcw = !inReset;
        v.pcw  = !inReset;
        v.srcb = 2'b01;
        return v;
    endfunction

    function automatic vec_t vAdr(input logic [3:0] st);
        vec_t v = vBlank(st);
        v.srcb = 2'b10;
        v.aluc = 3'b111;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t e, input string name);
        expQ.push_back(e);
        nameQ.push_back(name);
        @(posedge clk);
        #1;
    endtask

    task automatic runC(input logic [8:0] func, input logic [2:0] aluc, input logic a3);
        vec_t v;
        bus.Op   = 4'b1000;
        bus.Func = func;
        applyStimulus(vFetch(1'b0), "c_fetch");
        applyStimulus(vBlank(4'd1), "c_decode");
        v = vBlank(4'd9); v.srca = 2'b10; v.aluc = aluc;
        applyStimulus(v, "c_ex");
        v = vBlank(4'd10); v.rw = 1'b1; v.a3 = a3;
        applyStimulus(v, "c_wb");
    endtask

    task automatic runI(input logic [3:0] op, input logic [1:0] imm, input logic [2:0] aluc);
        vec_t v;
        bus.Op = op;
        applyStimulus(vFetch(1'b0), "i_fetch");
        applyStimulus(vBlank(4'd1), "i_decode");
        v = vBlank(4'd11); v.srca = 2'b10; v.srcb = 2'b10; v.imm = imm; v.aluc = aluc;
        applyStimulus(v, "i_ex");
        v = vBlank(4'd12); v.rw = 1'b1;
        applyStimulus(v, "i_wb");
    endtask

    task automatic runBrz(input logic zero);
        vec_t v;
        bus.Op   = 4'b0100;
        bus.Zero = zero;
        applyStimulus(vFetch(1'b0), "brz_fetch");
        applyStimulus(vBlank(4'd1), "brz_decode");
        v = vBlank(4'd8); v.srca = 2'b10; v.aluc = 3'b110; v.pcs = 2'b10; v.pcw = zero;
        applyStimulus(v, zero ? "brz_taken" : "brz_not_taken");
        bus.Zero = 1'b0;
    endtask

    task automatic checkOutput();
        int waited = 0;
        while (expQ.size() > 0 && waited < 20) begin
            @(posedge clk);
            waited++;
        end
        if (expQ.size() > 0) begin
            checks++;
            $display("[TB] FAIL drain: %0d expected vectors left, required 0", expQ.size());
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    endtask

    initial begin
        vec_t v;
        reset    = 1'b1;
        bus.Op   = 4'b0000;
        bus.Func = 9'h000;
        bus.Zero = 1'b0;
        @(posedge clk);
        #1;
        applyStimulus(vFetch(1'b1), "reset_fetch_1");
        applyStimulus(vFetch(1'b1), "reset_fetch_2");
        reset = 1'b0;

        // LD: 0,1,2,3,4
        bus.Op = 4'b0000;
        applyStimulus(vFetch(1'b0), "ld_fetch");
        applyStimulus(vBlank(4'd1), "ld_decode");
        applyStimulus(vAdr(4'd2), "ld_adr");
        v = vBlank(4'd3); v.adr = 1'b1; v.mdrw = 1'b1;
        applyStimulus(v, "ld_mem");
        v = vBlank(4'd4); v.rw = 1'b1; v.res = 1'b1;
        applyStimulus(v, "ld_wb");

        // ST: 0,1,5,6
        bus.Op = 4'b0001;
        applyStimulus(vFetch(1'b0), "st_fetch");
        applyStimulus(vBlank(4'd1), "st_decode");
        applyStimulus(vAdr(4'd5), "st_adr");
        v = vBlank(4'd6); v.adr = 1'b1; v.mw = 1'b1;
        applyStimulus(v, "st_mem");

        // JMP: 0,1,7
        bus.Op = 4'b0010;
        applyStimulus(vFetch(1'b0), "jmp_fetch");
        applyStimulus(vBlank(4'd1), "jmp_decode");
        v = vBlank(4'd7); v.pcs = 2'b01; v.pcw = 1'b1;
        applyStimulus(v, "jmp");

        runBrz(1'b1);
        runBrz(1'b0);

        runC(9'h001, 3'b110, 1'b1);
        runC(9'h00C, 3'b000, 1'b0);
        runC(9'h002, 3'b111, 1'b0);
        runC(9'h008, 3'b001, 1'b0);
        runC(9'h030, 3'b010, 1'b0);
        runC(9'h020, 3'b011, 1'b0);
        runC(9'h140, 3'b100, 1'b0);

        // C NOP: two-cycle instruction, no RegWrite
        bus.Op   = 4'b1000;
        bus.Func = 9'h080;
        applyStimulus(vFetch(1'b0), "nop_fetch");
        applyStimulus(vBlank(4'd1), "nop_decode");

        runI(4'b1101, 2'b01, 3'b001);
        runI(4'b1100, 2'b01, 3'b000);
        runI(4'b1110, 2'b00, 3'b010);
        runI(4'b1111, 2'b00, 3'b011);

        // Reset during LD_MEM abandons the load
        bus.Op = 4'b0000;
        applyStimulus(vFetch(1'b0), "ldr_fetch");
        applyStimulus(vBlank(4'd1), "ldr_decode");
        applyStimulus(vAdr(4'd2), "ldr_adr");
        reset = 1'b1;
        v = vBlank(4'd3); v.adr = 1'b1;
        applyStimulus(v, "ldr_mem_in_reset");
        reset = 1'b0;
        bus.Op = 4'b0010;
        applyStimulus(vFetch(1'b0), "ldr_refetch");
        applyStimulus(vBlank(4'd1), "ldr_jmp_decode");
        v = vBlank(4'd7); v.pcs = 2'b01; v.pcw = 1'b1;
        applyStimulus(v, "ldr_jmp");

        // Illegal opcode halts in ILL until reset
        bus.Op = 4'b0011;
        applyStimulus(vFetch(1'b0), "ill_fetch");
        applyStimulus(vBlank(4'd1), "ill_decode");
        v = vBlank(4'd15); v.ill = 1'b1;
        for (int i = 0; i < 10; i++) applyStimulus(v, "ill_hold");
        reset = 1'b1;
        applyStimulus(v, "ill_in_reset");
        reset = 1'b0;
        bus.Op = 4'b0010;
        applyStimulus(vFetch(1'b0), "ill_cleared_fetch");
        applyStimulus(vBlank(4'd1), "ill_cleared_decode");

        checkOutput();
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Moore FSM that sequences the 16-bit accumulator multicycle datapath: fetch, decode, execute, memory and writeback phases.
- Takes Op, Func and Zero from the datapath and drives every datapath control input.
- R0 is the accumulator (RF port A1 is hard-wired to R0); Ri is Instr[11:9].
- Also provides a sticky illegal-opcode flag and a state observation port for the bench.

Parameters:
- none (state encoding is fixed, listed under Behaviour)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- Op  in  4  Instr[15:12]
- Func  in  9  Instr[8:0], one-hot C-type function
- Zero  in  1  ALU zero flag, combinational from the current cycle
- AdrSrc  out  1  0 selects PC, 1 selects ALUOut
- MemWrite, IRWrite, RegWrite, PCWrite, OldPCWrite, MDRWrite  out  1 each  enables
- ALUSrcA  out  2  00 PC, 01 OldPC, 10 A
- ALUSrcB  out  2  00 B, 01 const 1, 10 ImmExt
- ImmSrc  out  2  00 zero-extend Instr[11:0], 01 sign-extend Instr[11:0]
- ALUControl  out  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 NOT SrcA, 110 PASS SrcA, 111 PASS SrcB
- A3Src  out  1  0 writes R0, 1 writes Ri
- PCSrc  out  2  00 ALUResult, 01 jump target, 10 branch target
- ResultSrc  out  1  0 selects ALUOut, 1 selects MDR
- illegal  out  1  sticky undefined-opcode flag
- state  out  4  current state code

Behaviour:
- One state register; all outputs decode from the state (Moore). The only exception is PCWrite in BRZ, which also depends on Zero.
- Every output not listed for a state is 0.
- Reset:
  - While reset=1, all write enables (MemWrite, IRWrite, RegWrite, PCWrite, OldPCWrite, MDRWrite) are forced to 0.
  - Next state is FETCH; illegal clears to 0.
  - A reset mid-instruction abandons it with no partial write on that edge.
- States and codes:
  - FETCH (0): AdrSrc=0, IRWrite=1, OldPCWrite=1, ALUSrcA=00, ALUSrcB=01, ADD, PCSrc=00, PCWrite=1. Next state is DECODE.
  - DECODE (1): no enables asserted (A and B load from the RF). Next state by Op:
    - 0000 LD → LD_ADR
    - 0001 ST → ST_ADR
    - 0010 JMP → JMP
    - 0100 BRZ → BRZ
    - 1000 C-type → C_EX, or FETCH if Func is NOP
    - 1100/1101/1110/1111 ADDI/SUBI/ANDI/ORI → I_EX
    - any other Op → ILL
  - LD_ADR (2) and ST_ADR (5): ALUSrcB=10, ImmSrc=00, PASS SrcB. Next state is LD_MEM or ST_MEM respectively.
  - LD_MEM (3): AdrSrc=1, MDRWrite=1. Next state is LD_WB.
  - LD_WB (4): RegWrite=1, A3Src=0, ResultSrc=1. Next state is FETCH.
  - ST_MEM (6): AdrSrc=1, MemWrite=1 (write data is A = R0). Next state is FETCH.
  - JMP (7): PCSrc=01, PCWrite=1. Next state is FETCH.
  - BRZ (8): ALUSrcA=10, PASS SrcA, PCSrc=10, PCWrite=Zero. Next state is FETCH.
  - C_EX (9): ALUSrcA=10, ALUSrcB=00. ALUControl is chosen by the lowest set Func bit:
    - bit0 MOVETO: PASS A
    - bit1 MOVEFROM: PASS B
    - bit2 ADD, bit3 SUB, bit4 AND, bit5 OR
    - bit6 NOT
    - Func[6:0]=0 (bit7, bit8 or zero) is NOP and is decided in DECODE.
    - The decoded Func is held in a 3-bit register captured in DECODE, so C_WB does not re-decode.
    - Next state is C_WB.
  - C_WB (10): RegWrite=1, ResultSrc=0. A3Src=1 for MOVETO, 0 for all others. Next state is FETCH.
  - I_EX (11): ALUSrcA=10, ALUSrcB=10.
    - ADDI: ImmSrc=01, ADD. SUBI: ImmSrc=01, SUB. ANDI: ImmSrc=00, AND. ORI: ImmSrc=00, OR.
    - The op is captured in DECODE. Next state is I_WB.
  - I_WB (12): RegWrite=1, A3Src=0, ResultSrc=0. Next state is FETCH.
  - ILL (15): illegal is set to 1 and stays set until reset. The state stays in ILL and all enables are 0 (the core halts).
- Latency in cycles: LD 5, ST 4, JMP 3, BRZ 3, C-type 4, C NOP 2, immediate 4.
- Multiple Func bits set: lowest bit wins; no error is flagged.
- Unused state codes 13 and 14 go to FETCH on the next edge with all enables 0.

Test Plan:
- Reset held 3 cycles, then released → PCWrite/IRWrite/RegWrite/MemWrite all 0 during reset; state=0 on the first cycle after release; FETCH asserts PCWrite=1, IRWrite=1, ALUSrcB=01, ALUControl=000.
- Op=0000 → states 0,1,2,3,4,0; MDRWrite=1 only in state 3; RegWrite=1, ResultSrc=1, A3Src=0 only in state 4. Op=0001 → MemWrite=1 exactly one cycle (state 6) with AdrSrc=1.
- Op=0100 with Zero=1 in BRZ → PCWrite=1, PCSrc=10. Repeat with Zero=0 → PCWrite=0. Both take 3 cycles.
- Op=1000:
  - Func=9'h001 → C_WB with A3Src=1, ALUControl=110 in C_EX.
  - Func=9'h00C → SUB is not chosen; ADD (000) wins.
  - Func=9'h080 → DECODE returns to FETCH; 2-cycle instruction with no RegWrite.
- Op=1101 → I_EX drives ImmSrc=01, ALUSrcB=10, ALUControl=001; I_WB drives RegWrite=1. Op=0011 → ILL with illegal=1 held 10 cycles; reset then clears it to 0 and restarts at FETCH.
- Reset asserted during LD_MEM → the next edge goes to FETCH with no RegWrite pulse; normal fetch resumes after release.
